// File: rtl/dma_buf_fifo.sv
// Byte-granular circular FIFO between the peripheral-side and memory-side ports of a DMA channel.
// Every write and every read carries its own size, so data is packed and unpacked between
// mismatched bus widths. The block also gives a fill-threshold flag, a flush, and error pulses.
module dma_buf_fifo #(
  parameter int unsigned wbus  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                              i_clk,
  input  logic                              i_nreset,
  input  logic [wbus-1:0]                   i_wdata,
  input  logic [1:0]                        i_wsize,
  input  logic                              i_put,
  input  logic [1:0]                        i_rsize,
  input  logic                              i_pull,
  input  logic                              i_flush,
  input  logic [1:0]                        i_fth,
  output logic [wbus-1:0]                   o_rdata,
  output logic [$clog2(DEPTH*wbus/8):0]     o_count,
  output logic                              o_empty,
  output logic                              o_full,
  output logic                              o_thr,
  output logic                              o_ovf,
  output logic                              o_udf
);

  localparam int unsigned BYTES = wbus / 8;
  localparam int unsigned CAP   = DEPTH * BYTES;
  localparam int unsigned AW    = $clog2(CAP);
  localparam int unsigned CW    = AW + 1;
  // Extra headroom so transfer sizes up to 8 bytes never overflow in the comparisons.
  localparam int unsigned EW    = CW + 4;
  localparam int unsigned MAXSZ = $clog2(BYTES);

  if (!(wbus == 8 || wbus == 16 || wbus == 32 || wbus == 64)) begin : g_bad_wbus
    $error("dma_buf_fifo: wbus must be 8, 16, 32 or 64");
  end
  if (CAP < 4 || (CAP & (CAP - 1)) != 0) begin : g_bad_cap
    $error("dma_buf_fifo: capacity in bytes must be a power of two and at least 4");
  end

  logic [7:0]    mem_q [CAP];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, udf_q;

  logic [EW-1:0] nw, nr, count_e, free_e, thr_e;
  logic          wlegal, rlegal, put_acc, pull_acc;

  // Decode transfer sizes and judge both requests against the pre-edge count.
  always_comb begin
    wlegal   = 32'(i_wsize) <= MAXSZ;
    rlegal   = 32'(i_rsize) <= MAXSZ;
    nw       = EW'(1) << i_wsize;
    nr       = EW'(1) << i_rsize;
    count_e  = EW'(count_q);
    free_e   = EW'(CAP) - count_e;
    put_acc  = i_put && wlegal && (nw <= free_e);
    pull_acc = i_pull && rlegal && (nr <= count_e);
    count_d  = CW'(count_e + (put_acc ? nw : '0) - (pull_acc ? nr : '0));
  end

  // Storage, pointers, count and error pulses; flush overrides any request in the same cycle.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      for (int i = 0; i < int'(CAP); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (i_flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (put_acc) begin
        for (int k = 0; k < int'(BYTES); k++) begin
          if (EW'(k) < nw) mem_q[wptr_q + AW'(k)] <= i_wdata[8*k +: 8];
        end
        wptr_q <= wptr_q + AW'(nw);
      end
      if (pull_acc) rptr_q <= rptr_q + AW'(nr);
      count_q <= count_d;
      ovf_q   <= i_put && !put_acc;
      udf_q   <= i_pull && !pull_acc;
    end
  end

  // Little-endian read view from the read pointer; bytes beyond the read size are zero.
  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < int'(BYTES); k++) begin
      if (EW'(k) < nr) o_rdata[8*k +: 8] = mem_q[rptr_q + AW'(k)];
    end
  end

  // Status flags come from the count register only.
  always_comb begin
    thr_e   = EW'((32'(i_fth) + 32'd1) * (CAP / 4));
    o_count = count_q;
    o_empty = (count_q == '0);
    o_full  = (count_e == EW'(CAP));
    o_thr   = (count_e >= thr_e);
    o_ovf   = ovf_q;
    o_udf   = udf_q;
  end

endmodule

// File: tb/tb_dma_buf_fifo.sv
// Scoreboard bench for dma_buf_fifo (wbus=32, DEPTH=4): a byte-queue reference model predicts
// the observable state; a monitor on the falling edge pops predictions and compares.
module tb_dma_buf_fifo;

  logic        i_clk, i_nreset;
  logic [31:0] i_wdata;
  logic [1:0]  i_wsize, i_rsize, i_fth;
  logic        i_put, i_pull, i_flush;
  logic [31:0] o_rdata;
  logic [4:0]  o_count;
  logic        o_empty, o_full, o_thr, o_ovf, o_udf;

  dma_buf_fifo #(.wbus(32), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_nreset(i_nreset), .i_wdata(i_wdata), .i_wsize(i_wsize), .i_put(i_put),
    .i_rsize(i_rsize), .i_pull(i_pull), .i_flush(i_flush), .i_fth(i_fth), .o_rdata(o_rdata),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full), .o_thr(o_thr), .o_ovf(o_ovf),
    .o_udf(o_udf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int          cnt;
    logic        empty, full, thr, ovf, udf;
    logic [31:0] rd, rmask;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mq[$];        // bytes currently held, oldest first
  logic        m_ovf, m_udf;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Predict outputs for the current model state and the currently driven rsize/fth.
  task automatic push_expected();
    exp_t e;
    int   nr;
    nr      = 1 << int'(i_rsize);
    e.cnt   = mq.size();
    e.empty = (mq.size() == 0);
    e.full  = (mq.size() == 16);
    e.thr   = (mq.size() >= (int'(i_fth) + 1) * 4);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    e.rd    = '0;
    e.rmask = '0;
    for (int k = 0; k < 4; k++) begin
      if (k >= nr) e.rmask[8*k +: 8] = 8'hff;
      else if (k < mq.size()) begin
        e.rmask[8*k +: 8] = 8'hff;
        e.rd[8*k +: 8]    = mq[k];
      end
    end
    sbq.push_back(e);
  endtask

  // Reference rules applied at a clock edge with the inputs that were present there.
  task automatic model_update(input logic put, input logic [1:0] ws, input logic [31:0] wd,
                              input logic pull, input logic [1:0] rs, input logic fl);
    int  cnt, nw, nr;
    bit  pa, la;
    if (fl) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
      return;
    end
    cnt = mq.size();
    nw  = 1 << int'(ws);
    nr  = 1 << int'(rs);
    pa  = put && ws <= 2 && nw <= 16 - cnt;
    la  = pull && rs <= 2 && nr <= cnt;
    if (la) for (int k = 0; k < nr; k++) void'(mq.pop_front());
    if (pa) for (int k = 0; k < nw; k++) mq.push_back(wd[8*k +: 8]);
    m_ovf = put && !pa;
    m_udf = pull && !la;
  endtask

  task automatic step(input logic put, input logic [1:0] ws, input logic [31:0] wd,
                      input logic pull, input logic [1:0] rs, input logic fl,
                      input logic [1:0] fth);
    i_put = put; i_wsize = ws; i_wdata = wd; i_pull = pull; i_rsize = rs;
    i_flush = fl; i_fth = fth;
    push_expected();
    @(posedge i_clk);
    #1;
    model_update(put, ws, wd, pull, rs, fl);
  endtask

  task automatic wput(input logic [1:0] ws, input logic [31:0] wd);
    step(1'b1, ws, wd, 1'b0, 2'd2, 1'b0, 2'd1);
  endtask
  task automatic rpull(input logic [1:0] rs);
    step(1'b0, 2'd0, 32'h0, 1'b1, rs, 1'b0, 2'd1);
  endtask
  task automatic idle(input logic [1:0] rs);
    step(1'b0, 2'd0, 32'h0, 1'b0, rs, 1'b0, 2'd1);
  endtask

  // Monitor: compare every pending prediction against the DUT away from the active edge.
  always @(negedge i_clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("count", 32'(o_count), 32'(e.cnt));
      chk("empty", 32'(o_empty), 32'(e.empty));
      chk("full",  32'(o_full),  32'(e.full));
      chk("thr",   32'(o_thr),   32'(e.thr));
      chk("ovf",   32'(o_ovf),   32'(e.ovf));
      chk("udf",   32'(o_udf),   32'(e.udf));
      if (e.rmask != '0) chk("rdata", o_rdata & e.rmask, e.rd & e.rmask);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    i_nreset = 1'b0; i_put = 0; i_pull = 0; i_flush = 0;
    i_wsize = 0; i_rsize = 2; i_fth = 1; i_wdata = 0;
    m_ovf = 0; m_udf = 0;
    #3;
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full",  32'(o_full),  32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_ovf",   32'(o_ovf),   32'd0);
    chk("rst_udf",   32'(o_udf),   32'd0);
    @(negedge i_clk);
    i_nreset = 1'b1;
    @(posedge i_clk);
    #1;

    // Asynchronous reset in the middle of a fill.
    wput(2'd0, 32'h5a); wput(2'd0, 32'ha5); wput(2'd1, 32'hbeef);
    i_put = 0; i_pull = 0; i_rsize = 2;
    i_nreset = 1'b0;
    #1;
    chk("arst_count", 32'(o_count), 32'd0);
    chk("arst_empty", 32'(o_empty), 32'd1);
    chk("arst_rdata", o_rdata, 32'd0);
    mq.delete(); m_ovf = 0; m_udf = 0;
    @(negedge i_clk);
    i_nreset = 1'b1;
    @(posedge i_clk);
    #1;
    idle(2'd2);

    // Pack four bytes into a word.
    wput(2'd0, 32'h11); wput(2'd0, 32'h22); wput(2'd0, 32'h33); wput(2'd0, 32'h44);
    idle(2'd2);
    rpull(2'd2);
    idle(2'd2);

    // Unpack a word into halves, then underflow.
    wput(2'd2, 32'haabbccdd);
    rpull(2'd1); rpull(2'd1); rpull(2'd1);
    idle(2'd1); idle(2'd1);

    // Overflow and wrap: park both pointers at 14 so later words straddle index 15/0.
    step(1'b0, 2'd0, 32'h0, 1'b0, 2'd2, 1'b1, 2'd1);
    wput(2'd2, 32'h0); wput(2'd2, 32'h0); wput(2'd2, 32'h0); wput(2'd1, 32'h0);
    rpull(2'd2); rpull(2'd2); rpull(2'd2); rpull(2'd1);
    wput(2'd2, 32'h13121110); wput(2'd2, 32'h17161514);
    wput(2'd2, 32'h1b1a1918); wput(2'd2, 32'h1f1e1d1c);
    idle(2'd2);
    rpull(2'd0); rpull(2'd1);
    wput(2'd2, 32'hdeadbeef);
    idle(2'd2);
    rpull(2'd0);
    wput(2'd2, 32'h01020304);
    idle(2'd2);
    rpull(2'd2); rpull(2'd2); rpull(2'd2); rpull(2'd2);
    idle(2'd2);

    // Simultaneous put and pull at full and at half.
    wput(2'd2, 32'ha0a1a2a3); wput(2'd2, 32'hb0b1b2b3);
    wput(2'd2, 32'hc0c1c2c3); wput(2'd2, 32'hd0d1d2d3);
    step(1'b1, 2'd2, 32'he0e1e2e3, 1'b1, 2'd2, 1'b0, 2'd1);
    idle(2'd2);
    rpull(2'd2);
    step(1'b1, 2'd2, 32'hf0f1f2f3, 1'b1, 2'd2, 1'b0, 2'd1);
    idle(2'd2);

    // Threshold at 8 bytes, flush beats a put, illegal dword put.
    step(1'b0, 2'd0, 32'h0, 1'b0, 2'd2, 1'b1, 2'd1);
    for (int i = 0; i < 8; i++) wput(2'd0, 32'(i + 8'h60));
    idle(2'd2);
    step(1'b1, 2'd2, 32'h99999999, 1'b0, 2'd2, 1'b1, 2'd1);
    idle(2'd2);
    wput(2'd3, 32'h12345678);
    idle(2'd2); idle(2'd2);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [1:0] ws, rs;
      ws = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      rs = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      step(1'($urandom % 2), ws, $urandom, 1'($urandom % 2), rs, ($urandom % 40) == 0,
           2'($urandom % 4));
    end
    idle(2'd2);
    @(negedge i_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dma_buf_fifo.md
Name: dma_buf_fifo

Overview:
- Parametrised byte-granular FIFO for the DMA channel data path, replacing the single-word holding register between the peripheral-side and memory-side AHB ports.
- Stores DEPTH words of wbus bits as a circular byte buffer.
- Each write and each read independently carries a transfer size (byte/halfword/word/dword), so the block packs and unpacks between mismatched source and destination widths.
- Provides a fill-threshold flag for burst scheduling, a synchronous flush, and overflow/underflow error pulses.

Parameters:
- wbus, 32, data bus width in bits; legal values 8, 16, 32, 64.
- DEPTH, 4, storage depth in wbus-wide words.
- CAP = DEPTH*wbus/8 is the capacity in bytes. CAP must be a power of two and at least 4. This is checked at elaboration.

Ports:
- i_clk  in  1  clock, rising edge
- i_nreset  in  1  asynchronous, active-low reset
- i_wdata  in  wbus  write data; low 2^i_wsize bytes are used
- i_wsize  in  2  write size: 0=byte, 1=half, 2=word, 3=dword
- i_put  in  1  write request
- i_rsize  in  2  read size, same encoding as i_wsize
- i_pull  in  1  read request
- i_flush  in  1  synchronous flush
- i_fth  in  2  threshold select
- o_rdata  out  wbus  read data, combinational
- o_count  out  $clog2(CAP)+1  bytes stored
- o_empty  out  1  count==0
- o_full  out  1  count==CAP
- o_thr  out  1  count >= threshold
- o_ovf  out  1  put-rejected pulse
- o_udf  out  1  pull-rejected pulse

Behaviour:
- Reset (async): storage, write pointer, read pointer and count are 0; o_ovf=0, o_udf=0; o_empty=1, o_full=0, o_thr=0; o_rdata=0.
- Size rules:
  - Nw = 2^i_wsize; Nr = 2^i_rsize.
  - A size greater than log2(wbus/8) is illegal.
  - A request with an illegal size is rejected and raises o_ovf (put) or o_udf (pull).
- Put acceptance:
  - Accepted iff i_put, the size is legal, and Nw <= CAP - count, with count taken as the pre-edge value.
  - On acceptance, byte k of i_wdata (k < Nw) is written to storage[(wptr+k) mod CAP], and wptr advances by Nw mod CAP.
- Pull acceptance:
  - Accepted iff i_pull, the size is legal, and Nr <= count (pre-edge value).
  - On acceptance, rptr advances by Nr mod CAP.
- o_rdata:
  - Combinational from the current rptr and i_rsize, little-endian.
  - Byte k = storage[(rptr+k) mod CAP] for k < Nr; bytes at k >= Nr are 0.
  - Stored bytes are shown regardless of count or i_pull; the consumer qualifies with o_count.
- No bypass path: a byte put in cycle t is readable no earlier than cycle t+1.
- Simultaneous put and pull: each request is judged independently against the pre-edge count. Next count = count + (put_acc ? Nw : 0) - (pull_acc ? Nr : 0).
- Wrap-around: a transfer may straddle the storage end; bytes split across index CAP-1 and index 0.
- Flush:
  - i_flush=1 at an edge forces wptr=rptr=count=0 and ignores i_put/i_pull that cycle.
  - No o_ovf/o_udf is raised in a flush cycle; storage contents are not cleared.
- Error pulses:
  - o_ovf/o_udf are registered and high for exactly the one cycle after the rejected request.
  - A rejected request changes no state.
- Threshold: thr_bytes = (i_fth+1)*CAP/4; o_thr = (count >= thr_bytes). It is combinational from the count register and i_fth.
- Flags o_empty, o_full and o_count derive from the count register only, so they are glitch-free relative to the inputs.

Test Plan (wbus=32, DEPTH=4, CAP=16):
1. Reset -> o_empty=1, o_full=0, o_count=0, o_rdata=0, o_ovf=o_udf=0. Then assert i_nreset=0 mid-fill -> count=0 immediately, without waiting for a clock edge.
2. Pack: byte puts 0x11,0x22,0x33,0x44 -> o_count=4. With i_rsize=2, o_rdata=0x44332211. Pull word -> o_count=0, o_empty=1.
3. Unpack: word put 0xAABBCCDD; half pull -> o_rdata=0x0000CCDD before the edge; next half pull -> o_rdata=0x0000AABB; then o_count=0. A third half pull -> o_udf pulses 1 cycle, count stays 0.
4. Overflow and wrap:
   - Fill 16 bytes -> o_full=1.
   - Pull byte, half -> count=13. Word put -> rejected, o_ovf 1 cycle, count=13.
   - Pull byte -> count=12. Word put 0x01020304 -> accepted, straddles index 15/0, count=16.
   - Drain and check byte order.
5. Simultaneous at count=16: put word + pull word in one cycle -> pull accepted, put rejected. Result: count=12, o_ovf=1, o_udf=0. At count=8, put word + pull word -> count stays 8, no pulses.
6. Flush and threshold:
   - i_fth=1 (8 bytes): o_thr toggles 0->1 when count goes 7->8.
   - i_flush together with i_put of a word at count=8 -> count=0, o_thr=0, o_ovf=0.
   - i_wsize=3 put -> o_ovf pulse, count unchanged.
